// File: rtl/pong_pkg.sv
// Shared button indices and paddle-direction encodings for the pong input block.
package pong_pkg;

   localparam int NUM_BTN    = 6;
   localparam int BTN_P1_UP  = 0;
   localparam int BTN_P1_DN  = 1;
   localparam int BTN_P1_SRV = 2;
   localparam int BTN_P2_UP  = 3;
   localparam int BTN_P2_DN  = 4;
   localparam int BTN_P2_SRV = 5;

   // Two-bit signed direction: +1 up, -1 down, 0 hold.
   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP   = 2'b01;
   localparam dir_t DIR_DN   = 2'b11;
   localparam dir_t DIR_HOLD = 2'b00;

   // Both-pressed and none-pressed cancel to hold.
   function automatic dir_t dir_sel(input logic up, input logic dn);
      case ({up, dn})
         2'b10:   return DIR_UP;
         2'b01:   return DIR_DN;
         default: return DIR_HOLD;
      endcase
   endfunction

endpackage

// File: rtl/pong_input_if.sv
// Button/frame/serve signal bundle between the game core (master) and pong_input (slave).
interface pong_input_if;

   logic [5:0] btn_raw;
   logic       frame_tick;
   logic [1:0] srv_ack;
   logic [5:0] btn_lvl;
   logic [5:0] btn_rise;
   logic [1:0] p1_dir;
   logic [1:0] p2_dir;
   logic [1:0] srv_req;

   modport master (
      output btn_raw, frame_tick, srv_ack,
      input  btn_lvl, btn_rise, p1_dir, p2_dir, srv_req
   );

   modport slave (
      input  btn_raw, frame_tick, srv_ack,
      output btn_lvl, btn_rise, p1_dir, p2_dir, srv_req
   );

endinterface

// File: rtl/pong_debounce.sv
// One button channel: optional 2-flop synchronizer (PONG_INPUT_SYNC_EN), counter debounce, rise pulse.
module pong_debounce #(
   parameter int DEB_BITS = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic lvl_o,
   output logic rise_o
);

   localparam logic [DEB_BITS-1:0] CNT_TERM = {{(DEB_BITS-1){1'b1}}, 1'b0};
   localparam logic [DEB_BITS-1:0] CNT_ONE  = {{(DEB_BITS-1){1'b0}}, 1'b1};

   logic                din;
   logic [DEB_BITS-1:0] cnt_q, cnt_d;
   logic                lvl_q, lvl_d;
   logic                lvl_dly_q;
   logic                rise_q;

`ifdef PONG_INPUT_SYNC_EN
   logic sync1_q, sync2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   assign din = sync2_q;
`else
   assign din = raw_i;
`endif

   // Any match restarts the count, so lvl only moves after an unbroken run of mismatches.
   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (din == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TERM) begin
         lvl_d = ~lvl_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         lvl_q     <= 1'b0;
         lvl_dly_q <= 1'b0;
         rise_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_q;
         rise_q    <= lvl_q & ~lvl_dly_q;
      end
   end

   assign lvl_o  = lvl_q;
   assign rise_o = rise_q;

endmodule

// File: rtl/pong_input.sv
// Pong controller front end: six debounced buttons, frame-latched paddle directions, sticky serves.
// Define PONG_INPUT_SYNC_EN to insert a 2-flop synchronizer ahead of each debounce channel.
module pong_input
   import pong_pkg::*;
#(
   parameter int DEB_BITS = 16
) (
   input  logic         clk,
   input  logic         rst,
   pong_input_if.slave  bus
);

   logic [NUM_BTN-1:0] lvl;
   logic [NUM_BTN-1:0] rise;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      pong_debounce #(.DEB_BITS(DEB_BITS)) u_deb (
         .clk    (clk),
         .rst    (rst),
         .raw_i  (bus.btn_raw[i]),
         .lvl_o  (lvl[i]),
         .rise_o (rise[i])
      );
   end

   dir_t       p1_dir_q, p1_dir_d;
   dir_t       p2_dir_q, p2_dir_d;
   logic [1:0] srv_q, srv_d;

   // A fresh serve press wins over an ack landing in the same cycle.
   always_comb begin
      p1_dir_d = p1_dir_q;
      p2_dir_d = p2_dir_q;
      if (bus.frame_tick) begin
         p1_dir_d = dir_sel(lvl[BTN_P1_UP], lvl[BTN_P1_DN]);
         p2_dir_d = dir_sel(lvl[BTN_P2_UP], lvl[BTN_P2_DN]);
      end
      srv_d[0] = rise[BTN_P1_SRV] | (srv_q[0] & ~bus.srv_ack[0]);
      srv_d[1] = rise[BTN_P2_SRV] | (srv_q[1] & ~bus.srv_ack[1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         p1_dir_q <= DIR_HOLD;
         p2_dir_q <= DIR_HOLD;
         srv_q    <= '0;
      end else begin
         p1_dir_q <= p1_dir_d;
         p2_dir_q <= p2_dir_d;
         srv_q    <= srv_d;
      end
   end

   assign bus.btn_lvl  = lvl;
   assign bus.btn_rise = rise;
   assign bus.p1_dir   = p1_dir_q;
   assign bus.p2_dir   = p2_dir_q;
   assign bus.srv_req  = srv_q;

endmodule

// File: tb/tb_pong_input.sv
// Directed bench for pong_input (DEB_BITS=2): sample-history model checked every cycle plus literal pins.
module tb_pong_input;

   localparam int DB   = 2;
   localparam int DMAX = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pong_input_if ifc ();

   pong_input #(.DEB_BITS(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.slave)
   );

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   // Model state
   logic [5:0] m_lvl, m_prev, m_rise;
   logic [1:0] m_p1, m_p2, m_srv;
   bit   [5:0] samp[$];

   function automatic logic [1:0] enc(input int d);
      return 2'(d);
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   // lvl flips once the last DMAX samples since reset all disagree with it.
   always @(posedge clk) begin
      logic [5:0] nl;
      bit flip;
      if (rst) begin
         m_lvl = '0; m_prev = '0; m_rise = '0;
         m_p1 = '0; m_p2 = '0; m_srv = '0;
         samp.delete();
      end else begin
         m_srv[0] = m_rise[2] | (m_srv[0] & ~ifc.srv_ack[0]);
         m_srv[1] = m_rise[5] | (m_srv[1] & ~ifc.srv_ack[1]);
         if (ifc.frame_tick) begin
            m_p1 = enc(int'(m_lvl[0]) - int'(m_lvl[1]));
            m_p2 = enc(int'(m_lvl[3]) - int'(m_lvl[4]));
         end
         m_rise = m_lvl & ~m_prev;
         m_prev = m_lvl;
         samp.push_back(ifc.btn_raw);
         nl = m_lvl;
         if (samp.size() >= DMAX) begin
            for (int ch = 0; ch < 6; ch++) begin
               flip = 1'b1;
               for (int k = 0; k < DMAX; k++)
                  if (samp[samp.size()-1-k][ch] == m_lvl[ch]) flip = 1'b0;
               if (flip) nl[ch] = ~m_lvl[ch];
            end
         end
         m_lvl = nl;
         if (samp.size() > 8) void'(samp.pop_front());
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("lvl",  {2'b0, ifc.btn_lvl},  {2'b0, m_lvl});
         chk("rise", {2'b0, ifc.btn_rise}, {2'b0, m_rise});
         chk("p1",   {6'b0, ifc.p1_dir},   {6'b0, m_p1});
         chk("p2",   {6'b0, ifc.p2_dir},   {6'b0, m_p2});
         chk("srv",  {6'b0, ifc.srv_req},  {6'b0, m_srv});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      ifc.btn_raw    = '0;
      ifc.frame_tick = 1'b0;
      ifc.srv_ack    = '0;
      rst = 1'b1;
      cyc();
      check_en = 1'b1;
      cyc();
      chk("rst_lvl", {2'b0, ifc.btn_lvl}, 8'h00);
      chk("rst_srv", {6'b0, ifc.srv_req}, 8'h00);

      // Held p1_up from cycle 0: lvl at cycle 3, rise only at cycle 4
      rst = 1'b0;
      ifc.btn_raw[0] = 1'b1;
      cyc(); chk("c1_lvl0", {7'b0, ifc.btn_lvl[0]}, 8'h00);
      cyc(); chk("c2_lvl0", {7'b0, ifc.btn_lvl[0]}, 8'h00);
      cyc(); chk("c3_lvl0", {7'b0, ifc.btn_lvl[0]}, 8'h01);
             chk("c3_rise0", {7'b0, ifc.btn_rise[0]}, 8'h00);
      cyc(); chk("c4_rise0", {7'b0, ifc.btn_rise[0]}, 8'h01);
      cyc(); chk("c5_rise0", {7'b0, ifc.btn_rise[0]}, 8'h00);

      // 2-cycle glitch on p1_srv never debounces
      ifc.btn_raw[2] = 1'b1;
      cyc(); cyc();
      ifc.btn_raw[2] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("glitch_lvl2", {7'b0, ifc.btn_lvl[2]}, 8'h00);
         chk("glitch_srv0", {7'b0, ifc.srv_req[0]}, 8'h00);
      end

      // up only -> DIR_UP, held across a level change until next tick
      ifc.frame_tick = 1'b1;
      cyc(); ifc.frame_tick = 1'b0;
      chk("p1_up", {6'b0, ifc.p1_dir}, 8'h01);
      ifc.btn_raw[0] = 1'b0;
      ifc.btn_raw[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk("p1_hold", {6'b0, ifc.p1_dir}, 8'h01);
      end
      ifc.frame_tick = 1'b1;
      cyc(); ifc.frame_tick = 1'b0;
      chk("p1_dn", {6'b0, ifc.p1_dir}, 8'h03);

      // up and down both high -> hold; p2 down only
      ifc.btn_raw[0] = 1'b1;
      ifc.btn_raw[4] = 1'b1;
      repeat (4) cyc();
      ifc.frame_tick = 1'b1;
      cyc(); ifc.frame_tick = 1'b0;
      chk("p1_both", {6'b0, ifc.p1_dir}, 8'h00);
      chk("p2_dn",   {6'b0, ifc.p2_dir}, 8'h03);

      // p2 serve: set, retrigger coincident with ack stays set, lone ack clears
      ifc.btn_raw[5] = 1'b1;
      repeat (5) cyc();
      chk("srv1_set", {7'b0, ifc.srv_req[1]}, 8'h01);
      ifc.btn_raw[5] = 1'b0;
      repeat (4) cyc();
      ifc.btn_raw[5] = 1'b1;
      repeat (4) cyc();
      chk("rise5", {7'b0, ifc.btn_rise[5]}, 8'h01);
      ifc.srv_ack[1] = 1'b1;
      cyc();
      chk("srv1_win", {7'b0, ifc.srv_req[1]}, 8'h01);
      cyc();
      chk("srv1_ack", {7'b0, ifc.srv_req[1]}, 8'h00);
      cyc();
      chk("srv1_noop", {7'b0, ifc.srv_req[1]}, 8'h00);
      ifc.srv_ack[1] = 1'b0;
      ifc.srv_ack[0] = 1'b1;
      cyc();
      ifc.srv_ack[0] = 1'b0;

      // reset mid-count on p2_up, with other buttons held
      ifc.btn_raw[3] = 1'b1;
      cyc(); cyc();
      rst = 1'b1;
      ifc.frame_tick = 1'b1;
      ifc.srv_ack = 2'b11;
      cyc();
      chk("mid_rst_lvl",  {2'b0, ifc.btn_lvl},  8'h00);
      chk("mid_rst_rise", {2'b0, ifc.btn_rise}, 8'h00);
      chk("mid_rst_dir",  {4'b0, ifc.p1_dir, ifc.p2_dir}, 8'h00);
      chk("mid_rst_srv",  {6'b0, ifc.srv_req}, 8'h00);
      rst = 1'b0;
      ifc.frame_tick = 1'b0;
      ifc.srv_ack = 2'b00;
      cyc(); chk("post_rst1_lvl3", {7'b0, ifc.btn_lvl[3]}, 8'h00);
      cyc(); chk("post_rst2_lvl3", {7'b0, ifc.btn_lvl[3]}, 8'h00);
      cyc(); chk("post_rst3_lvl3", {7'b0, ifc.btn_lvl[3]}, 8'h01);
      repeat (4) cyc();

      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pong_input.md
PONG_INPUT -- requirements
Module: pong_input

Interface
REQ-001 SHALL have parameter DEB_BITS, default 16, debounce counter width; DEB_MAX = 2^DEB_BITS-1 cycles.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port btn_raw  input  6  raw pins: [0] p1_up, [1] p1_dn, [2] p1_srv, [3] p2_up, [4] p2_dn, [5] p2_srv.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse at the vsync falling edge.
REQ-006 SHALL have port srv_ack  input  2  [0] consumes p1 serve, [1] consumes p2 serve.
REQ-007 SHALL have port btn_lvl  output  6  debounced levels, same bit order as btn_raw.
REQ-008 SHALL have port btn_rise  output  6  one-cycle pulse on each 0->1 transition of btn_lvl.
REQ-009 SHALL have port p1_dir  output  2  signed frame-latched direction: +1 up, -1 down, 0 hold.
REQ-010 SHALL have port p2_dir  output  2  same encoding as p1_dir, for player 2.
REQ-011 SHALL have port srv_req  output  2  sticky serve requests: [0] p1, [1] p2.

Function
REQ-012 SHALL run one debounce channel per button with state lvl and counter cnt[DEB_BITS-1:0].
REQ-013 SHALL clear cnt on any cycle where the channel input equals lvl.
REQ-014 SHALL increment cnt on any cycle where the channel input differs from lvl.
REQ-015 SHALL toggle lvl and clear cnt on a mismatch cycle where cnt == DEB_MAX-1, so lvl changes after exactly DEB_MAX consecutive mismatch cycles.
REQ-016 SHALL restart the full DEB_MAX count when a glitch shorter than DEB_MAX cycles is followed by a match.
REQ-017 SHALL assert btn_rise[i] in the cycle after btn_lvl[i] goes 0->1, for exactly one cycle, with no pulse on 1->0.
REQ-018 SHALL update p1_dir/p2_dir only in the cycle after frame_tick, computed from btn_lvl at the cycle frame_tick is high, and hold them otherwise.
REQ-019 SHALL output dir 0 when up and down are both high or both low.
REQ-020 SHALL set srv_req[i] on the serve button's btn_rise and keep it set until srv_ack[i] is high.
REQ-021 SHALL leave srv_req[i] set when btn_rise and srv_ack[i] occur in the same cycle, because the new event wins.
REQ-022 SHALL treat srv_ack[i] while srv_req[i] is 0 as a no-op.
REQ-023 SHALL treat the two players fully independently, with no priority between them.

Reset
REQ-024 SHALL, on rst high at a clk edge, clear all lvl, cnt, sync flops, btn_rise, p1_dir, p2_dir and srv_req to 0.
REQ-025 SHALL discard any in-progress debounce count on reset, so a held button needs a full DEB_MAX count after reset.
REQ-026 SHALL give rst priority over frame_tick, srv_ack and all button activity.

Configuration
REQ-027 SHALL, when PONG_INPUT_SYNC_EN is defined, pass each btn_raw bit through a two-flop synchronizer before its debounce channel, adding 2 cycles of latency.
REQ-028 SHALL, when PONG_INPUT_SYNC_EN is undefined, feed btn_raw straight into the debounce channels; behaviour is otherwise identical.

Structure
REQ-029 SHALL take the button index constants and the direction encodings (DIR_UP=2'b01, DIR_DN=2'b11, DIR_HOLD=2'b00) from shared package pong_pkg.
REQ-030 SHALL implement one channel (optional sync, counter, lvl, rise) as sub-module pong_debounce, instantiated six times.

Verification
REQ-031 SHALL check, with DEB_BITS=2 and SYNC off, that btn_raw[0] held high from cycle 0 gives btn_lvl[0]=1 at cycle 3 and btn_rise[0]=1 only at cycle 4.
REQ-032 SHALL check, with DEB_BITS=2, that a btn_raw[2] pulse 2 cycles wide gives btn_lvl[2]=0 throughout and srv_req[0]=0.
REQ-033 SHALL check that p1 up=1, dn=0 debounced, then frame_tick, gives p1_dir=2'b01 the next cycle, held until the next frame_tick.
REQ-034 SHALL check that up and down both high, then frame_tick, gives p1_dir=2'b00.
REQ-035 SHALL check that srv_req[1] set, then btn_rise[5] coincident with srv_ack[1], leaves srv_req[1]=1; a lone ack the next cycle gives 0.
REQ-036 SHALL check that rst asserted mid-count with cnt=2 clears all outputs, and a button still held needs 3 further cycles for btn_lvl to rise.
